// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side view of the hazard/stall unit: ID/EX/MEM hazard inputs and stall/flush controls.
interface hazard_stall_unit_if;
  logic [4:0]  rs1_IR1;
  logic [4:0]  rs2_IR1;
  logic        uses_rs2_IR1;
  logic        MemRead_IR2;
  logic [4:0]  rd_IR2;
  logic        branch_taken_IR3;
  logic        mem_busy;
  logic        stall_pc;
  logic        stall_IR1;
  logic        bubble_IR2;
  logic        flush_IR1;
  logic        flush_IR2;
  logic        stall_all;
  logic        mem_timeout;
  logic [15:0] stall_count;

  modport master (
    output rs1_IR1, rs2_IR1, uses_rs2_IR1, MemRead_IR2, rd_IR2, branch_taken_IR3, mem_busy,
    input  stall_pc, stall_IR1, bubble_IR2, flush_IR1, flush_IR2, stall_all, mem_timeout,
           stall_count
  );

  modport slave (
    input  rs1_IR1, rs2_IR1, uses_rs2_IR1, MemRead_IR2, rd_IR2, branch_taken_IR3, mem_busy,
    output stall_pc, stall_IR1, bubble_IR2, flush_IR1, flush_IR2, stall_all, mem_timeout,
           stall_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use stall, taken-branch flush and data-memory freeze control with a timeout watchdog.
module hazard_stall_unit #(
  parameter int unsigned LOAD_LATENCY = 1,
  parameter int unsigned MEM_TIMEOUT  = 64
) (
  input logic                 clk,
  input logic                 reset,
  hazard_stall_unit_if.slave  hsu
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;
  localparam logic [1:0] StErr     = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  lu_cnt_q, lu_cnt_d;
  logic [7:0]  mem_cnt_q, mem_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic hazard;
  logic stall_pc, stall_ir1, bubble_ir2, flush_ir1, flush_ir2, stall_all;

  assign hazard = hsu.MemRead_IR2 && (hsu.rd_IR2 != 5'd0) &&
                  ((hsu.rd_IR2 == hsu.rs1_IR1) ||
                   (hsu.uses_rs2_IR1 && (hsu.rd_IR2 == hsu.rs2_IR1)));

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    mem_cnt_d     = mem_cnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_pc      = 1'b0;
    stall_ir1     = 1'b0;
    bubble_ir2    = 1'b0;
    flush_ir1     = 1'b0;
    flush_ir2     = 1'b0;
    stall_all     = 1'b0;
    case (state_q)
      StRun, StLuStall: begin
        if (hsu.branch_taken_IR3) begin
          flush_ir1 = 1'b1;
          flush_ir2 = 1'b1;
          lu_cnt_d  = 3'd0;
          state_d   = StRun;
        end else if (hsu.mem_busy) begin
          // Any pending load-use bubbles are dropped; the freeze takes over.
          stall_all = 1'b1;
          stall_pc  = 1'b1;
          stall_ir1 = 1'b1;
          lu_cnt_d  = 3'd0;
          mem_cnt_d = 8'd1;
          state_d   = StMemWait;
        end else if (state_q == StLuStall) begin
          stall_pc   = 1'b1;
          stall_ir1  = 1'b1;
          bubble_ir2 = 1'b1;
          lu_cnt_d   = lu_cnt_q - 3'd1;
          if (lu_cnt_q == 3'd1) state_d = StRun;
        end else if (hazard) begin
          stall_pc   = 1'b1;
          stall_ir1  = 1'b1;
          bubble_ir2 = 1'b1;
          if (LOAD_LATENCY > 1) begin
            lu_cnt_d = 3'(LOAD_LATENCY - 1);
            state_d  = StLuStall;
          end
        end
      end
      StMemWait: begin
        if (hsu.mem_busy) begin
          stall_all = 1'b1;
          stall_pc  = 1'b1;
          stall_ir1 = 1'b1;
          mem_cnt_d = mem_cnt_q + 8'd1;
          // mem_cnt counts busy cycles including the one that entered the wait.
          if (mem_cnt_d == 8'(MEM_TIMEOUT)) begin
            state_d       = StErr;
            mem_timeout_d = 1'b1;
          end
        end else begin
          mem_cnt_d = 8'd0;
          state_d   = StRun;
        end
      end
      default: begin
        stall_all = 1'b1;
        stall_pc  = 1'b1;
        stall_ir1 = 1'b1;
      end
    endcase
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_pc && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      lu_cnt_q      <= 3'd0;
      mem_cnt_q     <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      lu_cnt_q      <= lu_cnt_d;
      mem_cnt_q     <= mem_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hsu.stall_pc    = stall_pc;
  assign hsu.stall_IR1   = stall_ir1;
  assign hsu.bubble_IR2  = bubble_ir2;
  assign hsu.flush_IR1   = flush_ir1;
  assign hsu.flush_IR2   = flush_ir2;
  assign hsu.stall_all   = stall_all;
  assign hsu.mem_timeout = mem_timeout_q;
  assign hsu.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: two instances (LOAD_LATENCY 1 and 3, MEM_TIMEOUT 8).
module tb_hazard_stall_unit;

  // Control vector order: {stall_pc, stall_IR1, bubble_IR2, flush_IR1, flush_IR2, stall_all,
  // mem_timeout}
  localparam logic [6:0] CIdle = 7'b000_0000;
  localparam logic [6:0] CLu   = 7'b111_0000;
  localparam logic [6:0] CFl   = 7'b000_1100;
  localparam logic [6:0] CMem  = 7'b110_0010;
  localparam logic [6:0] CErr  = 7'b110_0011;

  typedef struct {
    string       tag;
    logic        sel;
    logic [6:0]  ctrl;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic use2 = 1'b0, mr = 1'b0, br = 1'b0, busy = 1'b0;
  logic sel = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_unit_if if1 ();
  hazard_stall_unit_if if3 ();

  assign if1.rs1_IR1 = rs1;   assign if3.rs1_IR1 = rs1;
  assign if1.rs2_IR1 = rs2;   assign if3.rs2_IR1 = rs2;
  assign if1.uses_rs2_IR1 = use2; assign if3.uses_rs2_IR1 = use2;
  assign if1.MemRead_IR2 = mr;    assign if3.MemRead_IR2 = mr;
  assign if1.rd_IR2 = rd;     assign if3.rd_IR2 = rd;
  assign if1.branch_taken_IR3 = br; assign if3.branch_taken_IR3 = br;
  assign if1.mem_busy = busy; assign if3.mem_busy = busy;

  hazard_stall_unit #(.LOAD_LATENCY(1), .MEM_TIMEOUT(8)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .hsu   (if1.slave)
  );

  hazard_stall_unit #(.LOAD_LATENCY(3), .MEM_TIMEOUT(8)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .hsu   (if3.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [6:0]  c;
      logic [15:0] n;
      e = sb.pop_front();
      if (e.sel) begin
        c = {if3.stall_pc, if3.stall_IR1, if3.bubble_IR2, if3.flush_IR1, if3.flush_IR2,
             if3.stall_all, if3.mem_timeout};
        n = if3.stall_count;
      end else begin
        c = {if1.stall_pc, if1.stall_IR1, if1.bubble_IR2, if1.flush_IR1, if1.flush_IR2,
             if1.stall_all, if1.mem_timeout};
        n = if1.stall_count;
      end
      check({e.tag, "_ctrl"}, 32'(c), 32'(e.ctrl));
      check({e.tag, "_cnt"}, 32'(n), 32'(e.cnt));
    end
  end

  task automatic drive(input logic [4:0] a_rs1, input logic [4:0] a_rs2, input logic a_use2,
                       input logic a_mr, input logic [4:0] a_rd, input logic a_br,
                       input logic a_busy);
    rs1 = a_rs1; rs2 = a_rs2; use2 = a_use2; mr = a_mr; rd = a_rd; br = a_br; busy = a_busy;
  endtask

  // Push the expectation for the current cycle, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [6:0] ctrl, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ctrl = ctrl; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("reset", CIdle, 16'd0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // LOAD_LATENCY = 1 instance
    sel = 1'b0;
    do_reset();
    drive(5, 0, 0, 1, 5, 0, 0);  step("lu1_rs1", CLu, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0);  step("lu1_done", CIdle, 16'd1);
    step("lu1_idle", CIdle, 16'd1);
    drive(0, 0, 0, 1, 0, 0, 0);  step("x0", CIdle, 16'd1);
    drive(1, 7, 0, 1, 7, 0, 0);  step("rs2_unused", CIdle, 16'd1);
    drive(5, 0, 0, 1, 5, 1, 1);  step("all_three", CFl, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 0);  step("after_all", CIdle, 16'd1);

    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);  step("mw1", CMem, 16'd0);
    step("mw2", CMem, 16'd1);
    drive(0, 0, 0, 0, 0, 1, 1);  step("mw3_br_ignored", CMem, 16'd2);
    drive(0, 0, 0, 0, 0, 0, 1);  step("mw4", CMem, 16'd3);
    drive(0, 0, 0, 0, 0, 0, 0);  step("mw_release", CIdle, 16'd4);
    step("mw_idle", CIdle, 16'd4);

    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step("to_busy", CMem, 16'(i));
    drive(0, 0, 0, 0, 0, 0, 0);  step("err_entry", CErr, 16'd8);
    step("err_hold", CErr, 16'd9);
    repeat (65600) @(posedge clk);
    #1;
    step("sat", CErr, 16'hFFFF);
    step("sat_hold", CErr, 16'hFFFF);
    do_reset();
    step("post_err", CIdle, 16'd0);

    // LOAD_LATENCY = 3 instance
    sel = 1'b1;
    do_reset();
    drive(0, 9, 1, 1, 9, 0, 0);  step("lu3_c1", CLu, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0);  step("lu3_c2", CLu, 16'd1);
    step("lu3_c3", CLu, 16'd2);
    step("lu3_done", CIdle, 16'd3);
    step("lu3_idle", CIdle, 16'd3);

    do_reset();
    drive(4, 0, 0, 1, 4, 0, 0);  step("lub_c1", CLu, 16'd0);
    drive(0, 0, 0, 0, 0, 1, 0);  step("lub_branch", CFl, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 0);  step("lub_idle", CIdle, 16'd1);
    step("lub_idle2", CIdle, 16'd1);

    do_reset();
    drive(4, 0, 0, 1, 4, 0, 0);  step("lum_c1", CLu, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 1);  step("lum_busy", CMem, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 0);  step("lum_release", CIdle, 16'd2);
    step("lum_idle", CIdle, 16'd2);

    @(posedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
